// File: rtl/sp_pkg.sv
// Shared definitions for serial_parallel_aligner: aligner state encoding and the default comma symbol.
package sp_pkg;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        ALIGN    = 2'd1,
        LOCKED   = 2'd2,
        ST_SPARE = 2'd3
    } sp_state_e;

    localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/sp_shift_cmp.sv
// Serial shift register presenting the candidate word that includes the current DATA_IN bit,
// plus its comparison against the comma symbol.
module sp_shift_cmp #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
    output logic [WIDTH-1:0] nw,
    output logic             match
);

    // Only the upper WIDTH-1 bits of the shift register feed the next candidate word.
    logic [WIDTH-2:0] sr_hi;

    assign nw    = {DATA_IN, sr_hi};
    assign match = (nw == COMMA);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sr_hi <= '0;
        end else begin
            sr_hi <= nw[WIDTH-1:1];
        end
    end

endmodule

// File: rtl/serial_parallel_aligner.sv
// Serial-to-parallel converter with comma-based word alignment.
// Optional macro SP_LOS_EN: drop lock after more than MAX_GAP consecutive non-comma words.
module serial_parallel_aligner
    import sp_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] COMMA       = WIDTH'(K28_5),
    parameter int               LOCK_COMMAS = 2,
    parameter int               MAX_GAP     = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             VALID_OUT,
    output logic             IS_COMMA,
    output logic             SYNC
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (LOCK_COMMAS > 1) ? $clog2(LOCK_COMMAS + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    sp_state_e        state, state_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [CW-1:0]    comma_cnt, comma_cnt_n;
    logic [WIDTH-1:0] nw;
    logic             match;
    logic             boundary;
    logic             emit;

    sp_shift_cmp #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_shift_cmp (
        .CLK     (CLK),
        .RESET   (RESET),
        .DATA_IN (DATA_IN),
        .nw      (nw),
        .match   (match)
    );

`ifdef SP_LOS_EN
    localparam int GW = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
`endif

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt + 1'b1;
        comma_cnt_n = comma_cnt;
        boundary    = 1'b0;
        emit        = 1'b0;
`ifdef SP_LOS_EN
        gap_cnt_n   = gap_cnt;
`endif
        case (state)
            HUNT: begin
                if (match) begin
                    boundary    = 1'b1;
                    comma_cnt_n = CW'(1);
                    state_n     = (LOCK_COMMAS == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (bit_cnt == LAST_BIT) begin
                    boundary = 1'b1;
                    if (match) begin
                        comma_cnt_n = comma_cnt + 1'b1;
                        if (comma_cnt >= CW'(LOCK_COMMAS - 1)) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        comma_cnt_n = '0;
                        state_n     = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (bit_cnt == LAST_BIT) begin
                    boundary = 1'b1;
                    emit     = 1'b1;
`ifdef SP_LOS_EN
                    // The word that exceeds the gap is still emitted; lock drops afterwards.
                    if (match) begin
                        gap_cnt_n = '0;
                    end else if (gap_cnt == GW'(MAX_GAP)) begin
                        gap_cnt_n   = '0;
                        comma_cnt_n = '0;
                        state_n     = HUNT;
                    end else begin
                        gap_cnt_n = gap_cnt + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_n     = HUNT;
                comma_cnt_n = '0;
`ifdef SP_LOS_EN
                gap_cnt_n   = '0;
`endif
            end
        endcase
        if (boundary || state == ST_SPARE) begin
            bit_cnt_n = '0;
        end
    end

    // VALID_OUT is a one-cycle strobe without back-pressure; DATA_OUT and IS_COMMA are meaningful in that cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            DATA_OUT  <= '0;
            VALID_OUT <= 1'b0;
            IS_COMMA  <= 1'b0;
`ifdef SP_LOS_EN
            gap_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            comma_cnt <= comma_cnt_n;
            VALID_OUT <= emit;
            IS_COMMA  <= emit & match;
            if (boundary) begin
                DATA_OUT <= nw;
            end
`ifdef SP_LOS_EN
            gap_cnt   <= gap_cnt_n;
`endif
        end
    end

    assign SYNC = (state == LOCKED);

endmodule
